rr_grant_arb: RTL and testbench

- Round-robin arbiter that shares one downstream resource among N requesters, e.g. a shared register bank or a shared bus port built from the team's synchronous flops.
- Grants one requester at a time and holds the grant until release, owner request drop, or a hold timeout.
- Grant state is fully registered, so downstream enables come straight from flops.

---
 rtl/rr_grant_arb.sv | 120 ++++++++++++
 tb/tb_rr_grant_arb.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_arb.sv
// rr_grant_arb: round-robin arbiter, one registered one-hot grant at a time.
// Grant is held until done, owner request drop, or MAX_HOLD expiry.
module rr_grant_arb #(
  parameter int N        = 4,
  parameter int IDW      = 2,
  parameter int MAX_HOLD = 16,
  parameter int CNTW     = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic [N-1:0]   gnt,
  output logic           gnt_vld,
  output logic [IDW-1:0] gnt_id,
  output logic           timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNTW-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '0 : CNTW'(MAX_HOLD - 1);
  localparam logic [CNTW-1:0] CNT_MAX  = '1;
  localparam logic [IDW-1:0]  LAST_ID  = IDW'(N - 1);
  localparam logic [IDW:0]    N_EXT    = (IDW+1)'(N);

  state_t          state, state_nx;
  logic [IDW-1:0]  ptr, ptr_nx;
  logic [IDW-1:0]  gnt_id_nx;
  logic [CNTW-1:0] hold_cnt, hold_cnt_nx;
  logic [N-1:0]    gnt_nx;
  logic            vld_nx;
  logic            to_nx;

  logic [2*N-1:0]  req2;
  logic [N-1:0]    rot;
  logic [IDW:0]    sum;
  logic [IDW-1:0]  win;
  logic            found;

  logic            own_req;
  logic            to_hit;
  logic            rel;

  // rotate so that index ptr sits at bit 0, then take the lowest set bit
  always_comb begin
    req2  = {req, req} >> ptr;
    rot   = req2[N-1:0];
    win   = '0;
    found = 1'b0;
    sum   = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (IDW+1)'(i);
        if (sum >= N_EXT) sum = sum - N_EXT;
        win   = sum[IDW-1:0];
      end
    end
  end

  assign own_req = |(req & gnt);
  assign to_hit  = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
  assign rel     = done || !own_req || to_hit;

  always_comb begin
    state_nx    = state;
    ptr_nx      = ptr;
    gnt_id_nx   = gnt_id;
    hold_cnt_nx = hold_cnt;
    gnt_nx      = gnt;
    vld_nx      = gnt_vld;
    to_nx       = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_nx    = BUSY;
          gnt_nx      = N'(1) << win;
          vld_nx      = 1'b1;
          gnt_id_nx   = win;
          hold_cnt_nx = '0;
        end
      end
      BUSY: begin
        if (rel) begin
          state_nx    = IDLE;
          gnt_nx      = '0;
          vld_nx      = 1'b0;
          hold_cnt_nx = '0;
          ptr_nx      = (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
          to_nx       = to_hit && !done && own_req;
        end else if (hold_cnt != CNT_MAX) begin
          hold_cnt_nx = hold_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      gnt_vld  <= 1'b0;
      gnt_id   <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      hold_cnt <= hold_cnt_nx;
      gnt      <= gnt_nx;
      gnt_vld  <= vld_nx;
      gnt_id   <= gnt_id_nx;
      timeout  <= to_nx;
    end
  end

endmodule

// File: tb/tb_rr_grant_arb.sv
// tb_rr_grant_arb: directed and random stimulus, scoreboarded against
// a per-cycle reference model of the arbitration rules.
module tb_rr_grant_arb;

  localparam int N  = 4;
  localparam int MH = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] gnt;
  logic         gnt_vld;
  logic [1:0]   gnt_id;
  logic         timeout;

  rr_grant_arb #(.N(N), .IDW(2), .MAX_HOLD(MH), .CNTW(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] gnt;
    logic         vld;
    logic [1:0]   id;
    logic         to;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // model: owner index (-1 none), cycles the grant has been high so far
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  int m_last  = 0;
  bit m_to    = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(bit r, logic [N-1:0] rq, bit d);
    bit rd, rr, rt;
    exp_t e;
    if (!r) begin
      m_owner = -1; m_ptr = 0; m_held = 0; m_last = 0; m_to = 0;
    end else if (m_owner < 0) begin
      m_to = 0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (m_owner < 0 && rq[c]) begin
          m_owner = c; m_last = c; m_held = 1;
        end
      end
    end else begin
      rd = d;
      rr = !rq[m_owner];
      rt = (MH > 0) && (m_held == MH);
      if (rd || rr || rt) begin
        m_to    = rt && !rd && !rr;
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        m_held++;
        m_to = 0;
      end
    end
    e.gnt = (m_owner >= 0) ? N'(1) << m_owner : '0;
    e.vld = (m_owner >= 0);
    e.id  = 2'(m_last);
    e.to  = m_to;
    q.push_back(e);
  endtask

  task automatic step(bit r, logic [N-1:0] rq, bit d);
    rst_n = r;
    req   = rq;
    done  = d;
    model_edge(r, rq, d);
    @(posedge clk);
    #2;
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("gnt",     32'(gnt),     32'(e.gnt));
      chk("gnt_vld", 32'(gnt_vld), 32'(e.vld));
      chk("gnt_id",  32'(gnt_id),  32'(e.id));
      chk("timeout", 32'(timeout), 32'(e.to));
      chk("onehot",  32'($countones(gnt) <= 1), 32'(1));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req = '0; done = 1'b0;
    #1;
    // reset with all requesting
    repeat (3) step(0, 4'b1111, 0);
    step(1, 4'b1111, 0);
    chk("first_gnt", 32'(gnt), 32'h1);

    // priority and latency
    step(0, 4'b0000, 0);
    step(1, 4'b0110, 0);
    chk("prio_gnt", 32'(gnt), 32'h2);
    step(1, 4'b0110, 1);
    chk("prio_gap", 32'(gnt), 32'h0);
    step(1, 4'b0110, 0);
    chk("prio_next", 32'(gnt), 32'h4);
    step(1, 4'b0110, 1);

    // fairness: done on every 3rd grant cycle
    step(0, 4'b1111, 0);
    for (int g = 0; g < 6; g++) begin
      step(1, 4'b1111, 0);
      chk("fair_id", 32'(gnt_id), 32'(g % N));
      step(1, 4'b1111, 0);
      step(1, 4'b1111, 0);
      step(1, 4'b1111, 1);
    end

    // timeout on a lone requester
    step(0, 4'b0000, 0);
    for (int c = 0; c < 12; c++) step(1, 4'b1000, 0);
    step(1, 4'b0000, 0);

    // coincident done + drop + timeout
    step(1, 4'b1000, 0);
    repeat (3) step(1, 4'b1000, 0);
    step(1, 4'b0000, 1);
    chk("coinc_to", 32'(timeout), 32'h0);
    // owner drop alone
    step(1, 4'b0100, 0);
    step(1, 4'b0100, 0);
    step(1, 4'b0000, 0);
    // done in idle
    repeat (3) step(1, 4'b0000, 1);

    // reset mid-grant
    step(1, 4'b0100, 0);
    step(1, 4'b0100, 0);
    step(0, 4'b1111, 0);
    chk("rst_mid", 32'(gnt), 32'h0);
    step(1, 4'b1111, 0);
    chk("rst_ptr", 32'(gnt), 32'h1);

    // random traffic
    for (int c = 0; c < 600; c++) begin
      logic [N-1:0] r;
      r = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : req;
      step(($urandom_range(0, 49) != 0), r,
           ($urandom_range(0, 5) == 0));
    end

    step(1, 4'b0000, 0);
    chk("queue_drain", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
